// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector and stall sequencer between decode and the ID/EX register.
// Holds PC and IF/ID and bubbles the control bundle for STALL_CYCLES cycles per hazard.
module hazard_stall_ctrl #(
  parameter int REG_AW       = 5,
  parameter int CTRL_W       = 11,
  parameter int STALL_CYCLES = 1,
  parameter int ZERO_REG_EN  = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              id_ex_memread_i,
  input  logic [REG_AW-1:0] id_ex_rd_i,
  input  logic [REG_AW-1:0] if_id_rs1_i,
  input  logic [REG_AW-1:0] if_id_rs2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  input  logic              clr_cnt_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              hold_pc_o,
  output logic              hold_if_id_o,
  output logic              bubble_o,
  output logic              stall_busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The detect cycle itself is the first stall cycle, so the counter reloads with one less.
  localparam logic [3:0] RELOAD = 4'(STALL_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [3:0]       cnt;
  logic [CNT_W-1:0] perf_cnt;
  logic             hit1;
  logic             hit2;
  logic             rd_zero;
  logic             detect;
  logic             busy;
  logic             stall;
  logic             bubble;

  assign hit1    = rs1_used_i && (id_ex_rd_i == if_id_rs1_i);
  assign hit2    = rs2_used_i && (id_ex_rd_i == if_id_rs2_i);
  assign rd_zero = (ZERO_REG_EN != 0) && (id_ex_rd_i == '0);
  assign detect  = id_ex_memread_i && (hit1 || hit2) && !rd_zero;
  assign busy    = (cnt != 4'd0);

  // Flush overrides the stall: younger work is squashed but the PC must load the target.
  assign stall  = (detect || busy) && !flush_i;
  assign bubble = stall || flush_i;

  assign hold_pc_o    = stall;
  assign hold_if_id_o = stall;
  assign bubble_o     = bubble;
  assign ctrl_o       = bubble ? '0 : ctrl_i;
  assign stall_busy_o = busy;
  assign stall_cnt_o  = perf_cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt      <= 4'd0;
      perf_cnt <= '0;
    end else begin
      if (flush_i) begin
        cnt <= 4'd0;
      end else if (busy) begin
        cnt <= cnt - 4'd1;
      end else if (detect) begin
        cnt <= RELOAD;
      end

      if (clr_cnt_i) begin
        perf_cnt <= '0;
      end else if (stall) begin
        perf_cnt <= sat_inc(perf_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: three differently parameterised controllers share one stimulus stream
// and are checked against a cycle-level reference model of the stall rules.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        memread = 1'b0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        u1 = 1'b0;
  logic        u2 = 1'b0;
  logic [10:0] ctrl_in = '0;
  logic        flush = 1'b0;
  logic        clr = 1'b0;

  logic [10:0] ctrl_q [3];
  logic        hold_pc_q [3];
  logic        hold_ifid_q [3];
  logic        bubble_q [3];
  logic        busy_q [3];
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b;
  logic [2:0]  cnt_c;
  logic [15:0] cnt_x [3];

  assign cnt_x[0] = 16'(cnt_a);
  assign cnt_x[1] = cnt_b;
  assign cnt_x[2] = 16'(cnt_c);

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(2), .ZERO_REG_EN(1)) u_a (
    .clk(clk), .arst(arst), .id_ex_memread_i(memread), .id_ex_rd_i(rd),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
    .ctrl_i(ctrl_in), .flush_i(flush), .clr_cnt_i(clr), .ctrl_o(ctrl_q[0]),
    .hold_pc_o(hold_pc_q[0]), .hold_if_id_o(hold_ifid_q[0]), .bubble_o(bubble_q[0]),
    .stall_busy_o(busy_q[0]), .stall_cnt_o(cnt_a));

  hazard_stall_ctrl #(.STALL_CYCLES(3), .CNT_W(16), .ZERO_REG_EN(1)) u_b (
    .clk(clk), .arst(arst), .id_ex_memread_i(memread), .id_ex_rd_i(rd),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
    .ctrl_i(ctrl_in), .flush_i(flush), .clr_cnt_i(clr), .ctrl_o(ctrl_q[1]),
    .hold_pc_o(hold_pc_q[1]), .hold_if_id_o(hold_ifid_q[1]), .bubble_o(bubble_q[1]),
    .stall_busy_o(busy_q[1]), .stall_cnt_o(cnt_b));

  hazard_stall_ctrl #(.STALL_CYCLES(4), .CNT_W(3), .ZERO_REG_EN(0)) u_c (
    .clk(clk), .arst(arst), .id_ex_memread_i(memread), .id_ex_rd_i(rd),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
    .ctrl_i(ctrl_in), .flush_i(flush), .clr_cnt_i(clr), .ctrl_o(ctrl_q[2]),
    .hold_pc_o(hold_pc_q[2]), .hold_if_id_o(hold_ifid_q[2]), .bubble_o(bubble_q[2]),
    .stall_busy_o(busy_q[2]), .stall_cnt_o(cnt_c));

  typedef struct packed {
    logic [31:0]      cyc;
    logic [2:0]       hold;
    logic [2:0]       bub;
    logic [2:0]       busy;
    logic [2:0][10:0] ctrl;
    logic [2:0][15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model: remaining stall cycles after this one, and the performance count.
  int sc [3]   = '{1, 3, 4};
  int ze [3]   = '{1, 1, 0};
  int cmax [3] = '{3, 65535, 7};
  int rem [3]  = '{0, 0, 0};
  int pc [3]   = '{0, 0, 0};

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp, input logic [31:0] c);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, d, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk("hold_pc", i, 32'(hold_pc_q[i]), 32'(e.hold[i]), e.cyc);
        chk("hold_if_id", i, 32'(hold_ifid_q[i]), 32'(e.hold[i]), e.cyc);
        chk("bubble", i, 32'(bubble_q[i]), 32'(e.bub[i]), e.cyc);
        chk("ctrl", i, 32'(ctrl_q[i]), 32'(e.ctrl[i]), e.cyc);
        chk("busy", i, 32'(busy_q[i]), 32'(e.busy[i]), e.cyc);
        chk("stall_cnt", i, 32'(cnt_x[i]), 32'(e.cnt[i]), e.cyc);
      end
    end
  end

  task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic e1, input logic e2,
                       input logic [10:0] c, input logic fl, input logic cl, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    memread = mr; rd = d; rs1 = s1; rs2 = s2; u1 = e1; u2 = e2;
    ctrl_in = c; flush = fl; clr = cl; arst = rst;
    cyc++;
    e = '0;
    e.cyc = 32'(cyc);
    for (int i = 0; i < 3; i++) begin
      bit det;
      bit st;
      if (rst) begin
        rem[i] = 0;
        pc[i] = 0;
      end
      det = mr && ((e1 && d == s1) || (e2 && d == s2)) && !(ze[i] != 0 && d == 0);
      st = !fl && (rem[i] > 0 || det);
      e.hold[i] = st;
      e.bub[i] = st || fl;
      e.busy[i] = (rem[i] > 0);
      e.ctrl[i] = (st || fl) ? 11'd0 : c;
      e.cnt[i] = 16'(pc[i]);
      if (!rst) begin
        if (fl) rem[i] = 0;
        else if (rem[i] > 0) rem[i] = rem[i] - 1;
        else if (det) rem[i] = sc[i] - 1;
        if (cl) pc[i] = 0;
        else if (st && pc[i] < cmax[i]) pc[i] = pc[i] + 1;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h2a5, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h15a, 1'b0, 1'b0, 1'b1);
    idle(1);
    // rs1 hazard on x5
    drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 11'h7ff, 1'b0, 1'b0, 1'b0);
    idle(5);
    // rs2 hazard on x7
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 11'h3c3, 1'b0, 1'b0, 1'b0);
    idle(5);
    // load to x0, then a match on an unused source
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 11'h0f0, 1'b0, 1'b0, 1'b0);
    idle(5);
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1, 11'h111, 1'b0, 1'b0, 1'b0);
    idle(2);
    // flush in the second stall cycle
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 11'h222, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h333, 1'b1, 1'b0, 1'b0);
    idle(4);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b0, 11'h444, 1'b0, 1'b0, 1'b0);
      idle(5);
    end
    // clear together with a stall
    drive(1'b1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b0, 11'h555, 1'b0, 1'b1, 1'b0);
    idle(5);
    // reset during a multi-cycle stall
    drive(1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 11'h666, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h777, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0aa, 1'b0, 1'b0, 1'b1);
    idle(4);
    for (int k = 0; k < 800; k++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      drive(r ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), r);
    end
    idle(1);
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
